// File: rtl/branch_calc_pkg.sv
// Shared definitions for the branch-metric calculator: mode encodings,
// address-width helper and the clamp used on the halved metric.
package branch_calc_pkg;

   typedef enum logic [1:0] {
      MODE_PMS  = 2'd0,   // p - s
      MODE_SPP  = 2'd1,   // s + p
      MODE_NSPP = 2'd2,   // -(s + p)
      MODE_SMP  = 2'd3    // s - p
   } mode_e;

   function automatic int calc_aw(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   // Clamp a sign-extended value into the signed range of a dw-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/branch_calc_lane.sv
// One lane of the metric datapath: stage 1 holds the signed sum,
// stage 2 holds the halved and clamped metric.
module branch_calc_lane
   import branch_calc_pkg::*;
#(
   parameter int DWIDTH      = 16,
   parameter int USE_APRIORI = 0
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     en1,
   input  logic                     en2,
   input  logic signed [DWIDTH-1:0] sys,
   input  logic signed [DWIDTH-1:0] parity,
   input  logic signed [DWIDTH-1:0] apriori,
   input  mode_e                    mode,
   output logic signed [DWIDTH-1:0] data,
   output logic                     sat
);

   // Two guard bits cover -(s + p) + a for all operand values.
   localparam int SW = DWIDTH + 2;

   logic signed [SW-1:0] s_ext;
   logic signed [SW-1:0] p_ext;
   logic signed [SW-1:0] a_ext;
   logic signed [SW-1:0] sum_c;
   logic signed [SW-1:0] sum_q;
   logic signed [SW-1:0] half_c;
   logic signed [63:0]   half_wide;
   logic signed [63:0]   clamp_wide;

   always_comb begin
      s_ext = SW'(sys);
      p_ext = SW'(parity);
      a_ext = (USE_APRIORI != 0) ? SW'(apriori) : '0;
      sum_c = '0;
      case (mode)
         MODE_PMS:  sum_c = p_ext - s_ext + a_ext;
         MODE_SPP:  sum_c = s_ext + p_ext + a_ext;
         MODE_NSPP: sum_c = a_ext - (s_ext + p_ext);
         MODE_SMP:  sum_c = s_ext - p_ext + a_ext;
         default:   sum_c = '0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         sum_q <= '0;
      end else if (en1) begin
         sum_q <= sum_c;
      end
   end

   always_comb begin
      half_c     = sum_q >>> 1;
      half_wide  = 64'(half_c);
      clamp_wide = saturate(half_wide, DWIDTH);
      sat        = (clamp_wide != half_wide);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         data <= '0;
      end else if (en2) begin
         data <= DWIDTH'(clamp_wide);
      end
   end

endmodule

// File: rtl/branch_metric_calc.sv
// Multi-lane branch-metric calculator: two-stage pipeline with valid/ready
// flow control, carried address/last tag and a sticky saturation flag.
module branch_metric_calc
   import branch_calc_pkg::*;
#(
   parameter  int DWIDTH      = 16,
   parameter  int BRANCH_SIZE = 3072,
   parameter  int LANES       = 1,
   parameter  int USE_APRIORI = 0,
   localparam int AW          = calc_aw(BRANCH_SIZE)
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [LANES*DWIDTH-1:0]   s_sys,
   input  logic [LANES*DWIDTH-1:0]   s_parity,
   input  logic [LANES*DWIDTH-1:0]   s_apriori,
   input  logic [1:0]                s_mode,
   input  logic [AW-1:0]             s_addr,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [LANES*DWIDTH-1:0]   m_data,
   output logic [AW-1:0]             m_addr,
   output logic                      m_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      o_sat,
   input  logic                      i_sat_clear
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(BRANCH_SIZE - LANES);

   logic             st1_valid;
   logic [AW-1:0]    st1_addr;
   logic             st1_last;
   logic             en1;
   logic             en2;
   logic             ld1;
   logic             ld2;
   logic [LANES-1:0] lane_sat;

   // Valid/ready: a beat transfers on any edge where valid && ready. A stage
   // may advance when it is empty or its successor advances, so s_ready is a
   // combinational function of m_ready through both stages. Data registers
   // load only when a real beat moves (ld1/ld2); valids follow en1/en2.
   always_comb begin
      en2     = !m_valid || m_ready;
      en1     = !st1_valid || en2;
      s_ready = en1;
      ld1     = s_valid && en1;
      ld2     = st1_valid && en2;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      branch_calc_lane #(
         .DWIDTH      (DWIDTH),
         .USE_APRIORI (USE_APRIORI)
      ) u_lane (
         .aclk    (aclk),
         .aresetn (aresetn),
         .en1     (ld1),
         .en2     (ld2),
         .sys     (s_sys[i*DWIDTH +: DWIDTH]),
         .parity  (s_parity[i*DWIDTH +: DWIDTH]),
         .apriori (s_apriori[i*DWIDTH +: DWIDTH]),
         .mode    (mode_e'(s_mode)),
         .data    (m_data[i*DWIDTH +: DWIDTH]),
         .sat     (lane_sat[i])
      );
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         st1_valid <= 1'b0;
         st1_addr  <= '0;
         st1_last  <= 1'b0;
      end else begin
         if (en1) st1_valid <= s_valid;
         if (ld1) begin
            st1_addr <= s_addr;
            st1_last <= (s_addr == LAST_ADDR);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_last  <= 1'b0;
      end else begin
         if (en2) m_valid <= st1_valid;
         if (ld2) begin
            m_addr <= st1_addr;
            m_last <= st1_last;
         end
      end
   end

   // A saturating beat entering stage 2 overrides a simultaneous clear.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         o_sat <= 1'b0;
      end else if (ld2 && (|lane_sat)) begin
         o_sat <= 1'b1;
      end else if (i_sat_clear) begin
         o_sat <= 1'b0;
      end
   end

endmodule

// File: tb/tb_branch_metric_calc.sv
// Directed bench: a single-lane instance without a-priori (scoreboarded) and
// a two-lane instance with a-priori (checked per beat).
module tb_branch_metric_calc;
   import branch_calc_pkg::*;

   localparam int DW = 16;
   localparam int AW = 12;
   localparam int W  = AW + 1 + DW;

   // clock / reset
   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   int edge_cnt = 0;
   always @(posedge aclk) edge_cnt++;

   // single-lane instance
   logic [DW-1:0] s_sys_a, s_parity_a, s_apriori_a, m_data_a;
   logic [1:0]    s_mode_a;
   logic [AW-1:0] s_addr_a, m_addr_a;
   logic          s_valid_a, s_ready_a, m_last_a, m_valid_a, m_ready_a;
   logic          o_sat_a, i_sat_clear_a;

   branch_metric_calc #(.DWIDTH(DW), .BRANCH_SIZE(3072), .LANES(1), .USE_APRIORI(0)) dut_a (
      .aclk(aclk), .aresetn(aresetn),
      .s_sys(s_sys_a), .s_parity(s_parity_a), .s_apriori(s_apriori_a),
      .s_mode(s_mode_a), .s_addr(s_addr_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
      .m_data(m_data_a), .m_addr(m_addr_a), .m_last(m_last_a), .m_valid(m_valid_a),
      .m_ready(m_ready_a), .o_sat(o_sat_a), .i_sat_clear(i_sat_clear_a)
   );

   // two-lane instance with a-priori
   logic [2*DW-1:0] s_sys_b, s_parity_b, s_apriori_b, m_data_b;
   logic [1:0]      s_mode_b;
   logic [AW-1:0]   s_addr_b, m_addr_b;
   logic            s_valid_b, s_ready_b, m_last_b, m_valid_b, m_ready_b;
   logic            o_sat_b, i_sat_clear_b;

   branch_metric_calc #(.DWIDTH(DW), .BRANCH_SIZE(3072), .LANES(2), .USE_APRIORI(1)) dut_b (
      .aclk(aclk), .aresetn(aresetn),
      .s_sys(s_sys_b), .s_parity(s_parity_b), .s_apriori(s_apriori_b),
      .s_mode(s_mode_b), .s_addr(s_addr_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
      .m_data(m_data_b), .m_addr(m_addr_b), .m_last(m_last_b), .m_valid(m_valid_b),
      .m_ready(m_ready_b), .o_sat(o_sat_b), .i_sat_clear(i_sat_clear_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard for the single-lane instance: {addr, last, data}
   logic [W-1:0] exp_q[$];
   int           out_edge_q[$];
   int           last_acc_edge = 0;
   int           sready_low_cnt = 0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_word = '0;

   always @(negedge aclk) begin
      logic [W-1:0] cur;
      logic [W-1:0] exp;
      cur = {m_addr_a, m_last_a, m_data_a};
      if (aresetn) begin
         if (stall_prev) begin
            check("stall_valid_hold", {63'd0, m_valid_a}, 64'd1);
            check("stall_data_hold", 64'(cur), 64'(stall_word));
         end
         if (s_valid_a && !s_ready_a) sready_low_cnt++;
         if (m_valid_a && m_ready_a) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(cur), 64'd0);
            end else begin
               exp = exp_q.pop_front();
               check("out_beat", 64'(cur), 64'(exp));
               out_edge_q.push_back(edge_cnt + 1);
            end
         end
      end
      stall_prev = aresetn && m_valid_a && !m_ready_a;
      stall_word = cur;
   end

   // driver tasks; called at posedge+#1
   task automatic a_send(input logic [1:0] mode, input int s, input int p,
                         input int addr, input int exp_d);
      logic acc;
      acc         = 1'b0;
      s_mode_a    = mode;
      s_sys_a     = 16'(s);
      s_parity_a  = 16'(p);
      s_apriori_a = 16'd1000;
      s_addr_a    = 12'(addr);
      s_valid_a   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk);
         acc = s_ready_a;
         @(posedge aclk);
         if (acc) begin
            exp_q.push_back({12'(addr), (addr == 3071), 16'(exp_d)});
            break;
         end
      end
      #1;
      last_acc_edge = edge_cnt;
      s_valid_a = 1'b0;
      if (!acc) check("a_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge aclk);
         #1;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic b_run(input logic [1:0] mode, input int s0, input int p0, input int a0,
                        input int s1, input int p1, input int a1, input int addr,
                        input logic clr, output logic [31:0] d, output logic l,
                        output logic [AW-1:0] ad);
      logic acc;
      logic got;
      acc = 1'b0;
      got = 1'b0;
      d   = '0;
      l   = 1'b0;
      ad  = '0;
      s_mode_b    = mode;
      s_sys_b     = {16'(s1), 16'(s0)};
      s_parity_b  = {16'(p1), 16'(p0)};
      s_apriori_b = {16'(a1), 16'(a0)};
      s_addr_b    = 12'(addr);
      s_valid_b   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         acc = s_ready_b;
         @(posedge aclk);
         if (acc) break;
      end
      #1;
      s_valid_b     = 1'b0;
      i_sat_clear_b = clr;
      if (!acc) check("b_accept_timeout", 64'd0, 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (m_valid_b) begin
            got = 1'b1;
            d   = m_data_b;
            l   = m_last_b;
            ad  = m_addr_b;
         end
         @(posedge aclk);
         #1;
         i_sat_clear_b = 1'b0;
         if (got) break;
      end
      if (!got) check("b_output_timeout", 64'd0, 64'd1);
   endtask

   task automatic pulse_clear_b();
      i_sat_clear_b = 1'b1;
      @(posedge aclk);
      #1;
      i_sat_clear_b = 1'b0;
   endtask

   initial begin
      logic [31:0]   bd;
      logic          bl;
      logic [AW-1:0] ba;
      int            acc0;

      s_sys_a = '0; s_parity_a = '0; s_apriori_a = '0; s_mode_a = '0; s_addr_a = '0;
      s_valid_a = 1'b0; m_ready_a = 1'b1; i_sat_clear_a = 1'b0;
      s_sys_b = '0; s_parity_b = '0; s_apriori_b = '0; s_mode_b = '0; s_addr_b = '0;
      s_valid_b = 1'b0; m_ready_b = 1'b1; i_sat_clear_b = 1'b0;

      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;

      check("rst_m_valid", {63'd0, m_valid_a}, 64'd0);
      check("rst_m_data", 64'(m_data_a), 64'd0);
      check("rst_m_addr", 64'(m_addr_a), 64'd0);
      check("rst_m_last", {63'd0, m_last_a}, 64'd0);
      check("rst_o_sat", {63'd0, o_sat_a}, 64'd0);
      check("rst_s_ready", {63'd0, s_ready_a}, 64'd1);
      check("rst_b_m_valid", {63'd0, m_valid_b}, 64'd0);

      // mode 0 and latency; a-priori is ignored on this instance
      out_edge_q.delete();
      a_send(MODE_PMS, -50, 100, 1, 75);
      acc0 = last_acc_edge;
      wait_drain();
      check("latency", 64'((out_edge_q.size() > 0) ? out_edge_q[0] - acc0 : 999), 64'd2);
      a_send(MODE_PMS, 0, -3, 2, -2);
      wait_drain();

      // modes 1/2/3 back-to-back
      out_edge_q.delete();
      a_send(MODE_SPP, 10, 4, 3, 7);
      a_send(MODE_NSPP, 10, 4, 4, -7);
      a_send(MODE_SMP, 10, 4, 5, 3);
      wait_drain();
      check("burst_count", 64'(out_edge_q.size()), 64'd3);
      check("throughput", 64'((out_edge_q.size() == 3) ? out_edge_q[2] - out_edge_q[0] : 999), 64'd2);

      // positive saturation without a-priori, then the block's final address
      check("pre_sat_a", {63'd0, o_sat_a}, 64'd0);
      a_send(MODE_NSPP, -32768, -32768, 6, 32767);
      wait_drain();
      check("sat_a", {63'd0, o_sat_a}, 64'd1);
      a_send(MODE_PMS, 0, 2, 3071, 1);
      wait_drain();

      // 10-beat burst with a 5-cycle downstream stall
      sready_low_cnt = 0;
      fork
         begin
            for (int k = 0; k < 10; k++) a_send(MODE_SPP, k, 3 * k, k, 2 * k);
         end
         begin
            repeat (3) @(posedge aclk);
            #1;
            m_ready_a = 1'b0;
            repeat (5) @(posedge aclk);
            #1;
            m_ready_a = 1'b1;
         end
      join
      wait_drain();
      check("sready_fell", {63'd0, (sready_low_cnt > 0)}, 64'd1);

      // reset with two beats in flight
      a_send(MODE_NSPP, -32768, -32768, 20, 32767);
      a_send(MODE_PMS, 0, 10, 21, 5);
      check("inflight_valid", {63'd0, m_valid_a}, 64'd1);
      check("inflight_sat", {63'd0, o_sat_a}, 64'd1);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      exp_q.delete();
      check("post_rst_m_valid", {63'd0, m_valid_a}, 64'd0);
      check("post_rst_o_sat", {63'd0, o_sat_a}, 64'd0);
      check("post_rst_m_data", 64'(m_data_a), 64'd0);
      check("post_rst_s_ready", {63'd0, s_ready_a}, 64'd1);
      out_edge_q.delete();
      a_send(MODE_SMP, 100, 40, 22, 30);
      acc0 = last_acc_edge;
      wait_drain();
      check("post_rst_latency", 64'((out_edge_q.size() > 0) ? out_edge_q[0] - acc0 : 999), 64'd2);

      // two lanes with a-priori: lane0 saturates high, lane1 = (10+4+2)>>>1
      b_run(MODE_SPP, 32767, 32767, 32767, 10, 4, 2, 0, 1'b0, bd, bl, ba);
      check("b_sat_data", 64'(bd), 64'({16'd8, 16'h7FFF}));
      check("b_sat_flag", {63'd0, o_sat_b}, 64'd1);
      pulse_clear_b();
      check("b_clear", {63'd0, o_sat_b}, 64'd0);

      // lane0 = (10-4-20)>>>1 = -7, lane1 = 3, final beat of the block
      b_run(MODE_SMP, 10, 4, -20, 10, 4, 0, 3070, 1'b0, bd, bl, ba);
      check("b_smp_data", 64'(bd), 64'({16'd3, 16'hFFF9}));
      check("b_last_3070", {63'd0, bl}, 64'd1);
      check("b_addr_3070", 64'(ba), 64'd3070);
      check("b_no_sat", {63'd0, o_sat_b}, 64'd0);

      b_run(MODE_PMS, -50, 100, 0, 0, -3, 0, 3068, 1'b0, bd, bl, ba);
      check("b_pms_data", 64'(bd), 64'({16'hFFFE, 16'd75}));
      check("b_last_3068", {63'd0, bl}, 64'd0);

      // clear coinciding with a saturating beat entering stage 2
      b_run(MODE_SPP, 32767, 32767, 32767, 0, 0, 0, 5, 1'b1, bd, bl, ba);
      check("b_set_wins", {63'd0, o_sat_b}, 64'd1);
      pulse_clear_b();

      // negative saturation: -(32767+32767)-32768 >>> 1 clamps to -32768
      b_run(MODE_NSPP, 32767, 32767, -32768, 0, 0, 0, 6, 1'b0, bd, bl, ba);
      check("b_neg_sat_data", 64'(bd), 64'({16'd0, 16'h8000}));
      check("b_neg_sat_flag", {63'd0, o_sat_b}, 64'd1);

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_metric_calc.md
Name: branch_metric_calc

Overview:
- Parametrised multi-lane branch-metric calculator for the SISO decoder.
- Replaces the fixed single-lane "(parity - sys) >>> 1" branch service.
- Per beat it computes LANES metrics from systematic, parity and optional a-priori LLRs, in one of four sign modes, with saturation.
- Carries address and last flag alongside the data, with valid/ready backpressure between the input buffers and the trellis/gamma memory.

Parameters:
- DWIDTH, 16: signed LLR width of inputs and outputs.
- BRANCH_SIZE, 3072: items per block. Address width AW = $clog2(BRANCH_SIZE).
- LANES, 1: parallel items per beat. Lane i occupies bits [i*DWIDTH +: DWIDTH].
- USE_APRIORI, 0: 1 adds s_apriori into the metric; 0 ignores s_apriori.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: reset, synchronous, active-low.
- s_sys, in, LANES*DWIDTH: signed systematic LLRs.
- s_parity, in, LANES*DWIDTH: signed parity LLRs.
- s_apriori, in, LANES*DWIDTH: signed a-priori LLRs.
- s_mode, in, 2: metric mode for this beat, shared by all lanes.
- s_addr, in, AW: address of lane 0 item.
- s_valid, in, 1: input beat valid.
- s_ready, out, 1: input beat accepted when s_valid && s_ready.
- m_data, out, LANES*DWIDTH: signed saturated metrics.
- m_addr, out, AW: address carried with the beat.
- m_last, out, 1: high when the carried s_addr == BRANCH_SIZE-LANES (final beat of the block).
- m_valid, out, 1: output beat valid.
- m_ready, in, 1: downstream accept.
- o_sat, out, 1: sticky flag, any lane saturated since reset or clear.
- i_sat_clear, in, 1: clears o_sat.

Behaviour:
- Reset (aresetn low at a clock edge):
  - m_valid=0, m_data=0, m_addr=0, m_last=0, o_sat=0; all internal stage valids 0.
  - s_ready=1 in the cycle after reset deasserts.
  - Mid-operation reset drops all in-flight beats; nothing is replayed.
- Modes (per lane, operands sign-extended to DWIDTH+2):
  - 0: p - s.
  - 1: s + p.
  - 2: -(s + p).
  - 3: s - p.
  - If USE_APRIORI=1, add a; otherwise add 0.
- Result is (sum >>> 1), arithmetic shift, rounding toward -inf, then saturated to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- Pipeline:
  - Stage 1 registers sum (DWIDTH+2 bits), addr, last and valid.
  - Stage 2 registers the shifted, saturated data plus addr, last and valid. Stage 2 drives the m_* outputs.
- Latency: exactly 2 cycles from input handshake to m_valid when m_ready is held 1. Throughput is 1 beat/cycle.
- Handshake:
  - en2 = !st2_valid || m_ready.
  - en1 = !st1_valid || en2.
  - s_ready = en1 (combinational from m_ready, documented path).
- Stall:
  - m_valid=1 && m_ready=0 holds m_data, m_addr and m_last stable.
  - A stalled stage never loses or duplicates a beat; at most 2 beats are in flight.
- m_valid never drops without an m_ready handshake.
- Address: no wrap logic inside the block. m_last is computed from the carried address.
- Saturation flag:
  - o_sat sets in the cycle a saturated beat is registered into stage 2.
  - i_sat_clear clears it.
  - Clear and set in the same cycle: set wins.
- s_mode and s_apriori are sampled only on handshake. Mode may change every beat.

Decomposition:
- Package branch_calc_pkg holds:
  - mode encodings MODE_PMS=0, MODE_SPP=1, MODE_NSPP=2, MODE_SMP=3;
  - a saturate function;
  - the AW helper.
- Sub-module branch_calc_lane holds one lane's stage-1 sum and stage-2 shift/saturate datapath, with enables en1/en2, plus a per-lane sat output.
- The top level instantiates LANES copies and owns the handshake, the addr/last pipeline and o_sat.

Test Plan:
- LANES=1, mode 0, p=100, s=-50, m_ready=1 -> m_data=75 two cycles after accept. p=-3, s=0 -> m_data=-2.
- Modes 1/2/3 with s=10, p=4 -> 7, -7, 3 respectively, back-to-back beats, one result per cycle.
- USE_APRIORI=1, mode 1, s=p=a=32767 -> m_data=32767, o_sat=1. Then i_sat_clear pulse -> o_sat=0. Simultaneous clear and saturated beat -> o_sat stays 1.
- m_ready=0 for 5 cycles during a 10-beat burst of addrs 0..9 -> s_ready falls after 2 beats are held. Output order is addr 0..9 with no loss or duplication, and data is stable while stalled.
- BRANCH_SIZE=3072, LANES=2, addr 3070 -> m_last=1. Addr 3068 -> m_last=0.
- aresetn low for one cycle with 2 beats in flight -> m_valid=0 the next cycle, o_sat=0, and a new beat accepted after reset emerges 2 cycles later.
